// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM port between two pixel requesters.
// A tag pipeline matched to the ROM latency steers each returned palette index to its issuer.
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              last_grant
);

    generate
        if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_lat_chk
            $error("sprite_rom_arbiter: ROM_LAT must be 1 or 2");
        end
    endgenerate

    logic               gnt0, gnt1;
    logic               prio;       // 0: requester 0 wins a tie, 1: requester 1 wins
    logic [ROM_LAT-1:0] vld_pipe;
    logic [ROM_LAT-1:0] id_pipe;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0_valid & (~req1_valid | ~prio);
            gnt1 = req1_valid & (~req0_valid |  prio);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rom_en     = gnt0 | gnt1;
    assign rom_addr   = gnt0 ? req0_addr : (gnt1 ? req1_addr : '0);

    // prio tracks ~last_grant once anything is granted, but starts on requester 0 out of reset
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            prio       <= 1'b0;
            last_grant <= 1'b0;
            vld_pipe   <= '0;
            id_pipe    <= '0;
        end else begin
            if (rom_en) begin
                last_grant <= gnt1;
                prio       <= ~gnt1;
            end
            vld_pipe[0] <= rom_en;
            id_pipe[0]  <= gnt1;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= vld_pipe[ROM_LAT-1] & ~id_pipe[ROM_LAT-1];
            rsp1_valid <= vld_pipe[ROM_LAT-1] &  id_pipe[ROM_LAT-1];
            if (vld_pipe[ROM_LAT-1] && !id_pipe[ROM_LAT-1])
                rsp0_data <= rom_q;
            if (vld_pipe[ROM_LAT-1] && id_pipe[ROM_LAT-1])
                rsp1_data <= rom_q;
        end
    end

endmodule
